// File: rtl/fifo_lvl.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty
// thresholds, synchronous flush, sticky overflow/underflow and empty bypass.
module fifo_lvl #(
    parameter int NUM_ENTRIES = 16,
    parameter int DWIDTH      = 8,
    parameter int AF_THRESH   = NUM_ENTRIES - 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               flush,
    input  logic                               err_clr,
    input  logic [DWIDTH-1:0]                  idata,
    output logic [DWIDTH-1:0]                  odata,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int PW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CW = $clog2(NUM_ENTRIES + 1);

    // Depth need not be a power of two, so the wrap point is compared explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(NUM_ENTRIES - 1)) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [DWIDTH-1:0] mem_q [0:NUM_ENTRIES-1];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, afull_q, aempty_q;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_en_s, rd_en_s, ovf_evt_s, udf_evt_s;

    // Per-cycle operation decode in priority order.
    always_comb begin
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        ovf_evt_s = 1'b0;
        udf_evt_s = 1'b0;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else if (empty_q && push && pop) begin
            // Bypass: data flows straight through, state untouched.
            count_d = count_q;
        end else if (full_q && push && pop) begin
            wr_en_s = 1'b1;
            rd_en_s = 1'b1;
        end else if (full_q && push && !pop) begin
            ovf_evt_s = 1'b1;
        end else if (empty_q && pop && !push) begin
            udf_evt_s = 1'b1;
        end else begin
            wr_en_s = push;
            rd_en_s = pop;
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (wr_en_s) begin
            wptr_d = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_d;
        end
        if (rd_en_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_d;
        end
    end

    // Sticky error flags: a new event in the same cycle beats err_clr.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
            udf_d = udf_q;
        end
        if (ovf_evt_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
        if (udf_evt_s) begin
            udf_d = 1'b1;
        end else begin
            udf_d = udf_d;
        end
    end

    // Pointers, occupancy, status flags (flags derived from next count) and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(NUM_ENTRIES));
            empty_q  <= (count_d == CW'(0));
            afull_q  <= (count_d >= CW'(AF_THRESH));
            aempty_q <= (count_d <= CW'(AE_THRESH));
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array, cleared on reset so the head reads zero until first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[wptr_q] <= idata;
        end else begin
            mem_q[wptr_q] <= mem_q[wptr_q];
        end
    end

    // Show-ahead head with same-cycle bypass while empty.
    always_comb begin
        if (empty_q && push) begin
            odata = idata;
        end else begin
            odata = mem_q[rptr_q];
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed self-checking bench for fifo_lvl at NUM_ENTRIES=5, DWIDTH=8.
module tb_fifo_lvl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [7:0] idata = 8'h00;
    logic [7:0] odata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    int total = 0;
    int bad = 0;

    fifo_lvl #(.NUM_ENTRIES(5), .DWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
        .err_clr(err_clr), .idata(idata), .odata(odata), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; outputs are inspected 1 time unit after the edge.
    task automatic drive(input logic p, input logic q, input logic f, input logic e, input logic [7:0] d);
        push = p; pop = q; flush = f; err_clr = e; idata = d;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; idata = 8'h00;
    endtask

    task automatic test_reset;
        total++; if (count !== 3'd0) begin $display("FAIL reset_count got=%0d exp=0", count); bad++; end
        total++; if (empty !== 1'b1) begin $display("FAIL reset_empty got=%b exp=1", empty); bad++; end
        total++; if (full !== 1'b0) begin $display("FAIL reset_full got=%b exp=0", full); bad++; end
        total++; if (almost_empty !== 1'b1) begin $display("FAIL reset_ae got=%b exp=1", almost_empty); bad++; end
        total++; if (almost_full !== 1'b0) begin $display("FAIL reset_af got=%b exp=0", almost_full); bad++; end
        total++; if ({overflow, underflow} !== 2'b00) begin $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); bad++; end
        total++; if (odata !== 8'h00) begin $display("FAIL reset_odata got=%h exp=00", odata); bad++; end
    endtask

    task automatic test_fill_drain;
        logic [7:0] v;
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i * 17);
            drive(1'b1, 1'b0, 1'b0, 1'b0, v);
            total++; if (count !== 3'(i)) begin $display("FAIL fill_count got=%0d exp=%0d", count, i); bad++; end
            total++; if (full !== (i == 5)) begin $display("FAIL fill_full i=%0d got=%b", i, full); bad++; end
            total++; if (almost_full !== (i >= 3)) begin $display("FAIL fill_af i=%0d got=%b", i, almost_full); bad++; end
            total++; if (almost_empty !== (i <= 2)) begin $display("FAIL fill_ae i=%0d got=%b", i, almost_empty); bad++; end
            total++; if (odata !== 8'h11) begin $display("FAIL fill_head got=%h exp=11", odata); bad++; end
        end
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i * 17);
            total++; if (odata !== v) begin $display("FAIL drain_data got=%h exp=%h", odata, v); bad++; end
            drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            total++; if (count !== 3'(5 - i)) begin $display("FAIL drain_count got=%0d exp=%0d", count, 5 - i); bad++; end
        end
        total++; if (empty !== 1'b1) begin $display("FAIL drain_empty got=%b exp=1", empty); bad++; end
        total++; if (full !== 1'b0) begin $display("FAIL drain_full got=%b exp=0", full); bad++; end
    endtask

    task automatic test_wrap;
        logic [7:0] mq[$];
        int ops[12] = '{1, 3, 1, 2, 3, 2, 1, 1, 3, 2, 2, 1};
        logic [7:0] d = 8'h60;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, d); mq.push_back(d); d++;
        end
        for (int i = 0; i < 12; i++) begin
            logic p, q;
            p = (ops[i] != 2);
            q = (ops[i] != 1);
            drive(p, q, 1'b0, 1'b0, d);
            if (q) void'(mq.pop_front());
            if (p) begin mq.push_back(d); d++; end
            total++; if (count !== 3'(mq.size())) begin $display("FAIL wrap_count step=%0d got=%0d exp=%0d", i, count, mq.size()); bad++; end
            total++; if (odata !== mq[0]) begin $display("FAIL wrap_data step=%0d got=%h exp=%h", i, odata, mq[0]); bad++; end
        end
        while (mq.size() > 0) begin
            total++; if (odata !== mq[0]) begin $display("FAIL wrap_drain got=%h exp=%h", odata, mq[0]); bad++; end
            drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            void'(mq.pop_front());
        end
        total++; if (empty !== 1'b1 || count !== 3'd0) begin $display("FAIL wrap_end empty=%b count=%0d exp 1/0", empty, count); bad++; end
    endtask

    task automatic test_bypass;
        push = 1'b1; pop = 1'b1; idata = 8'hA5;
        #1;
        total++; if (odata !== 8'hA5) begin $display("FAIL bypass_odata got=%h exp=a5", odata); bad++; end
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; idata = 8'h00;
        total++; if (count !== 3'd0) begin $display("FAIL bypass_count got=%0d exp=0", count); bad++; end
        total++; if (empty !== 1'b1) begin $display("FAIL bypass_empty got=%b exp=1", empty); bad++; end
        total++; if (underflow !== 1'b0) begin $display("FAIL bypass_udf got=%b exp=0", underflow); bad++; end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_q[5] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hB6};
        for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0 + 8'(i));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
        total++; if (overflow !== 1'b1) begin $display("FAIL ovf_set got=%b exp=1", overflow); bad++; end
        total++; if (count !== 3'd5) begin $display("FAIL ovf_count got=%0d exp=5", count); bad++; end
        total++; if (odata !== 8'hA1) begin $display("FAIL ovf_head got=%h exp=a1", odata); bad++; end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hB6);
        total++; if (count !== 3'd5 || full !== 1'b1) begin $display("FAIL full_pushpop count=%0d full=%b exp 5/1", count, full); bad++; end
        total++; if (overflow !== 1'b1) begin $display("FAIL ovf_hold got=%b exp=1", overflow); bad++; end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        total++; if (overflow !== 1'b0) begin $display("FAIL ovf_clr got=%b exp=0", overflow); bad++; end
        for (int i = 0; i < 5; i++) begin
            total++; if (odata !== exp_q[i]) begin $display("FAIL ovf_drain got=%h exp=%h", odata, exp_q[i]); bad++; end
            drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        total++; if (empty !== 1'b1) begin $display("FAIL ovf_empty got=%b exp=1", empty); bad++; end
    endtask

    task automatic test_underflow;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        total++; if (underflow !== 1'b1) begin $display("FAIL udf_set got=%b exp=1", underflow); bad++; end
        total++; if (count !== 3'd0) begin $display("FAIL udf_count got=%0d exp=0", count); bad++; end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        total++; if (underflow !== 1'b1) begin $display("FAIL udf_setwins got=%b exp=1", underflow); bad++; end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        total++; if (underflow !== 1'b0) begin $display("FAIL udf_clr got=%b exp=0", underflow); bad++; end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hC0 + 8'(i));
        total++; if (count !== 3'd3) begin $display("FAIL flush_pre got=%0d exp=3", count); bad++; end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hCF);
        total++; if (count !== 3'd0) begin $display("FAIL flush_count got=%0d exp=0", count); bad++; end
        total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin $display("FAIL flush_flags empty=%b ae=%b exp 1/1", empty, almost_empty); bad++; end
        total++; if (almost_full !== 1'b0 || overflow !== 1'b0) begin $display("FAIL flush_af_ovf af=%b ovf=%b exp 0/0", almost_full, overflow); bad++; end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hD1);
        total++; if (odata !== 8'hD1 || count !== 3'd1) begin $display("FAIL flush_after odata=%h count=%0d exp d1/1", odata, count); bad++; end
    endtask

    task automatic test_async_reset;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h71);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h72);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h73);
        total++; if (count !== 3'd3 || almost_full !== 1'b1) begin $display("FAIL arst_pre count=%0d af=%b exp 3/1", count, almost_full); bad++; end
        push = 1'b1; idata = 8'h74;
        #2;
        rst_n = 1'b0; push = 1'b0; idata = 8'h00;
        #1;
        total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin $display("FAIL arst_cnt count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); bad++; end
        total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin $display("FAIL arst_thr ae=%b af=%b exp 1/0", almost_empty, almost_full); bad++; end
        total++; if (underflow !== 1'b0 || overflow !== 1'b0) begin $display("FAIL arst_err udf=%b ovf=%b exp 0/0", underflow, overflow); bad++; end
        total++; if (odata !== 8'h00) begin $display("FAIL arst_odata got=%h exp=00", odata); bad++; end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        total++; if (odata !== 8'h5A || count !== 3'd1) begin $display("FAIL arst_after odata=%h count=%0d exp 5a/1", odata, count); bad++; end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_bypass();
        test_overflow();
        test_underflow();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
# fifo_lvl

Parametrised synchronous FIFO: next generation of the single-clock FIFO. Adds arbitrary (non-power-of-two) depth, an occupancy count, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. Keeps show-ahead read data and same-cycle bypass when empty. Sits between producer/consumer pipeline stages wherever the plain FIFO is used today.

## Interface
- NUM_ENTRIES, 16, storage depth; any integer >= 2
- DWIDTH, 8, data width in bits
- AF_THRESH, NUM_ENTRIES-2, almost_full asserts when count >= AF_THRESH; legal range 1..NUM_ENTRIES
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..NUM_ENTRIES-1
- CW (local), clog2(NUM_ENTRIES+1), count width; pointer width PW = clog2(NUM_ENTRIES)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  write idata this cycle
- pop  in  1  consume head entry this cycle
- flush  in  1  synchronous clear of contents
- err_clr  in  1  clear sticky error flags
- idata  in  DWIDTH  write data
- odata  out  DWIDTH  head-of-queue data (show-ahead, combinational)
- full  out  1  count == NUM_ENTRIES (registered)
- empty  out  1  count == 0 (registered)
- almost_full  out  1  registered, see AF_THRESH
- almost_empty  out  1  registered, see AE_THRESH
- count  out  CW  current occupancy (registered)
- overflow  out  1  sticky: push dropped while full
- underflow  out  1  sticky: pop while empty with no bypass

## Operation
- Reset (rst_n low, any time, including mid-transfer): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0; storage array reset to 0, so odata = 0 until first push.
- Pointers wrap NUM_ENTRIES-1 -> 0 explicitly (no power-of-two masking).
- Accepted push (not bypass): storage[waddr] <= idata, waddr advances.
- Accepted pop (not bypass): raddr advances.
- Per-cycle decode, priority order:
  - flush: pointers and count to 0; push/pop that cycle ignored; error flags not set by them.
  - empty & push & pop: bypass; odata = idata; nothing written, pointers and count unchanged.
  - full & push & pop: both accepted; count unchanged; no overflow.
  - full & push & !pop: push dropped; overflow set.
  - empty & pop & !push: pop ignored; underflow set.
  - otherwise: count += push - pop.
- odata = idata when empty & push, else storage[raddr]. Undefined content (stale head) while empty with no push; bench does not check odata then.
- Flags (full, empty, almost_full, almost_empty) are registered from next-count, always consistent with count in the same cycle.
- err_clr clears overflow/underflow; if a new error event occurs in the same cycle, set wins.

## Timing
- Push in cycle N into empty FIFO: count=1, empty=0 visible cycle N+1; odata = written data in cycle N+1.
- Pop in cycle N: next entry on odata in cycle N+1.
- Bypass: zero latency, odata = idata combinationally in the same cycle.
- full asserts in the cycle after the NUM_ENTRIES-th accepted push; deasserts in the cycle after the first pop.
- Error flags assert the cycle after the offending event; clear the cycle after err_clr.
- flush effect visible in the next cycle: empty=1, count=0.

## Test plan
- NUM_ENTRIES=5, DWIDTH=8: push 0x11..0x55 -> count 1..5, full=1 after 5th push; almost_full=1 from count 3; pop 5 times -> odata 0x11,0x22,0x33,0x44,0x55 in order, empty=1.
- Wrap-around, NUM_ENTRIES=5: 12 push/pop interleaved with occupancy held at 2-4 -> data order preserved across pointer wrap 4->0; count never exceeds 5.
- Empty, push=pop=1, idata=0xA5 -> odata=0xA5 same cycle; next cycle count=0, empty=1, no underflow.
- Full, push=1 pop=0, idata=0xEE -> overflow=1 next cycle, count=5, 0xEE never appears on odata; then push=pop=1 -> count stays 5, overflow unchanged; err_clr -> overflow=0.
- Empty, pop=1 -> underflow=1; err_clr and pop-on-empty in the same cycle -> underflow stays 1.
- count=3, flush with push=1 -> next cycle count=0, empty=1; assert rst_n low mid-burst -> all outputs at reset values immediately (asynchronous), odata=0.
